// File: rtl/fifo_byte_packer.sv
// rtl/fifo_byte_packer.sv - packs bits popped from a bit-serial FIFO into LSB-first bytes
// Bytes go out on valid/ready; a flush request emits the current partial byte with its bit count.
module fifo_byte_packer #(
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_data_i,
  input  logic       fifo_empty_i,
  output logic       fifo_pop_o,
  input  logic       flush_i,
  output logic [7:0] byte_data_o,
  output logic [3:0] byte_count_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    POP   = 2'd1,
    GUARD = 2'd2,
    EMIT  = 2'd3
  } state_e;

  localparam logic [2:0] GUARD_RELOAD = 3'(GUARD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] guard_cnt_q, guard_cnt_d;
  logic       flush_pend_q, flush_pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 4'd0;
      guard_cnt_q  <= 3'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      guard_cnt_q  <= guard_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    guard_cnt_d  = guard_cnt_q;
    flush_pend_d = flush_pend_q | flush_i;

    case (state_q)
      FETCH: begin
        if (flush_pend_q && (bit_cnt_q != 4'd0)) begin
          state_d = EMIT;
        end else if (flush_pend_q) begin
          flush_pend_d = 1'b0;
        end else if (!fifo_empty_i) begin
          state_d = POP;
        end
      end
      POP: begin
        // Only reached with bit_cnt < 8, so the low three bits index the slot.
        shift_d[bit_cnt_q[2:0]] = fifo_data_i;
        bit_cnt_d               = bit_cnt_q + 4'd1;
        guard_cnt_d             = GUARD_RELOAD;
        state_d                 = GUARD;
      end
      GUARD: begin
        if (guard_cnt_q != 3'd0) begin
          guard_cnt_d = guard_cnt_q - 3'd1;
        end else if (bit_cnt_q == 4'd8) begin
          state_d = EMIT;
        end else begin
          state_d = FETCH;
        end
      end
      EMIT: begin
        if (byte_ready_i) begin
          shift_d   = 8'h00;
          bit_cnt_d = 4'd0;
          // A short byte can only come from a flush; full bytes leave a pending flush alone.
          if (bit_cnt_q != 4'd8) begin
            flush_pend_d = 1'b0;
          end
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign fifo_pop_o   = (state_q == POP);
  assign byte_valid_o = (state_q == EMIT);
  assign byte_data_o  = (state_q == EMIT) ? shift_q : 8'h00;
  assign byte_count_o = (state_q == EMIT) ? bit_cnt_q : 4'd0;

endmodule
